// File: rtl/f52_round_f32_if.sv
// Handshake and data bundle for the f52_round_f32 rounding stage.
// The slave view belongs to the rounder. The master view belongs to whatever drives it
// and consumes its results.
interface f52_round_f32_if;
  logic        i_v;
  logic        i_rdy;
  logic [51:0] i_a;
  logic [2:0]  i_rm;
  logic        o_v;
  logic        o_rdy;
  logic [51:0] o_a;
  logic        o_nx;
  logic        o_ov;

  modport master (
    output i_v, i_a, i_rm, o_rdy,
    input  i_rdy, o_v, o_a, o_nx, o_ov
  );

  modport slave (
    input  i_v, i_a, i_rm, o_rdy,
    output i_rdy, o_v, o_a, o_nx, o_ov
  );
endinterface

// File: rtl/f52_round_f32.sv
// Two-stage rounding of F52 (1/11/40) operands to 23-bit mantissa precision.
// The result's low 17 mantissa bits are zero, so a downstream truncating F52->F32
// narrowing yields a correctly rounded F32.
// Stage 1 classifies the operand and decides the increment.
// Stage 2 applies the increment and produces the per-result flags.
module f52_round_f32 (
  input  logic              clk,
  input  logic              rst,
  f52_round_f32_if.slave    bus,
  input  logic              clr_fl,
  output logic              fl_nx,
  output logic              fl_ov
);

  typedef enum logic [2:0] {ClsZero, ClsDenorm, ClsNorm, ClsInf, ClsNan} cls_e;

  // Input field split
  logic        in_sign;
  logic [10:0] in_exp;
  logic [39:0] in_man;
  logic        in_g;
  logic        in_s;
  logic        in_lsb;
  logic        in_inc;
  cls_e        in_cls;

  // Stage 1 state
  logic        s1_v_q;
  logic        s1_sign_q;
  logic [10:0] s1_exp_q;
  logic [22:0] s1_man_q;
  cls_e        s1_cls_q;
  logic        s1_inc_q;
  logic        s1_g_q;
  logic        s1_s_q;

  // Stage 2 state
  logic        s2_v_q;
  logic [51:0] o_a_q;
  logic        o_nx_q;
  logic        o_ov_q;
  logic        fl_nx_q;
  logic        fl_ov_q;

  // Stage 2 next-state values
  logic [51:0] res_a;
  logic        res_nx;
  logic        res_ov;
  logic [23:0] m24;
  logic [10:0] exp_inc;
  logic        fl_nx_d;
  logic        fl_ov_d;

  logic        s1_adv;
  logic        s2_adv;
  logic        out_xfer;

  assign in_sign = bus.i_a[51];
  assign in_exp  = bus.i_a[50:40];
  assign in_man  = bus.i_a[39:0];
  assign in_g    = in_man[16];
  assign in_s    = |in_man[15:0];
  assign in_lsb  = in_man[17];

  // Stall chain: a stage moves when it is empty or the stage after it is moving
  assign s2_adv   = ~s2_v_q | bus.o_rdy;
  assign s1_adv   = ~s1_v_q | s2_adv;
  assign out_xfer = s2_v_q & bus.o_rdy;

  assign bus.i_rdy = s1_adv;
  assign bus.o_v   = s2_v_q;
  assign bus.o_a   = o_a_q;
  assign bus.o_nx  = o_nx_q;
  assign bus.o_ov  = o_ov_q;
  assign fl_nx     = fl_nx_q;
  assign fl_ov     = fl_ov_q;

  // Rounding-mode increment decision and operand classification
  always_comb begin
    in_inc = 1'b0;
    case (bus.i_rm)
      3'd1:    in_inc = 1'b0;
      3'd2:    in_inc = in_sign & (in_g | in_s);
      3'd3:    in_inc = ~in_sign & (in_g | in_s);
      3'd4:    in_inc = in_g;
      default: in_inc = in_g & (in_s | in_lsb);
    endcase

    in_cls = ClsNorm;
    if (in_exp == 11'h000) begin
      in_cls = (in_man == 40'd0) ? ClsZero : ClsDenorm;
    end else if (in_exp == 11'h7FF) begin
      in_cls = (in_man == 40'd0) ? ClsInf : ClsNan;
    end
  end

  // Stage 1 capture on input transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= 11'd0;
      s1_man_q  <= 23'd0;
      s1_cls_q  <= ClsZero;
      s1_inc_q  <= 1'b0;
      s1_g_q    <= 1'b0;
      s1_s_q    <= 1'b0;
    end else if (s1_adv) begin
      s1_v_q <= bus.i_v;
      if (bus.i_v) begin
        s1_sign_q <= in_sign;
        s1_exp_q  <= in_exp;
        s1_man_q  <= in_man[39:17];
        s1_cls_q  <= in_cls;
        s1_inc_q  <= in_inc;
        s1_g_q    <= in_g;
        s1_s_q    <= in_s;
      end
    end
  end

  // Apply the increment and build the result for the decoded class
  always_comb begin
    m24     = {1'b0, s1_man_q} + {23'd0, s1_inc_q};
    exp_inc = s1_exp_q + 11'd1;
    res_a   = {s1_sign_q, 51'd0};
    res_nx  = 1'b0;
    res_ov  = 1'b0;
    unique case (s1_cls_q)
      ClsNorm: begin
        res_nx = s1_g_q | s1_s_q;
        if (m24[23]) begin
          // Mantissa wrapped to zero: bump the exponent, which may reach infinity
          res_a  = {s1_sign_q, exp_inc, 40'd0};
          res_ov = (exp_inc == 11'h7FF);
        end else begin
          res_a = {s1_sign_q, s1_exp_q, m24[22:0], 17'd0};
        end
      end
      ClsDenorm: begin
        res_nx = 1'b1;
      end
      ClsInf: begin
        res_a = {s1_sign_q, 11'h7FF, 40'd0};
      end
      ClsNan: begin
        // Force the quiet bit so truncation cannot turn the NaN into infinity
        res_a = {s1_sign_q, 11'h7FF, 1'b1, s1_man_q[21:0], 17'd0};
      end
      default: begin
        res_a = {s1_sign_q, 51'd0};
      end
    endcase
  end

  // Stage 2 capture; outputs hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q <= 1'b0;
      o_a_q  <= 52'd0;
      o_nx_q <= 1'b0;
      o_ov_q <= 1'b0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        o_a_q  <= res_a;
        o_nx_q <= res_nx;
        o_ov_q <= res_ov;
      end
    end
  end

  // A flag set on an output transfer wins over a simultaneous clear
  always_comb begin
    fl_nx_d = (clr_fl ? 1'b0 : fl_nx_q) | (out_xfer & o_nx_q);
    fl_ov_d = (clr_fl ? 1'b0 : fl_ov_q) | (out_xfer & o_ov_q);
  end

  // Sticky flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fl_nx_q <= 1'b0;
      fl_ov_q <= 1'b0;
    end else begin
      fl_nx_q <= fl_nx_d;
      fl_ov_q <= fl_ov_d;
    end
  end

endmodule

// File: doc/f52_round_f32.md
# f52_round_f32

Pipelined rounding stage that feeds the F52-to-F32 narrowing converter. It takes 52-bit floating-point values (1 sign, 11 exponent bits with bias 0x3FF, 40 mantissa bits) and rounds the mantissa to 23 bits under a selectable rounding mode. It emits an F52 value whose low 17 mantissa bits are zero, so the downstream truncating converter produces a correctly rounded F32. It also accumulates sticky inexact and overflow flags, and exchanges data with valid/ready handshakes on both sides.

## Interface
- No parameters; all formats are fixed at F52 (1/11/40) with 23-bit target precision.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- i_v  in  1  input valid
- i_rdy  out  1  input ready; a transfer occurs when i_v and i_rdy are both high
- i_a  in  52  operand {sign, exp[10:0], man[39:0]}
- i_rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5–7 behave as RNE
- o_v  out  1  output valid
- o_rdy  in  1  downstream ready
- o_a  out  52  rounded result, with o_a[16:0] always 0
- o_nx  out  1  inexact, per result (valid with o_v)
- o_ov  out  1  overflow to infinity, per result
- fl_nx  out  1  sticky inexact, accumulated
- fl_ov  out  1  sticky overflow, accumulated
- clr_fl  in  1  clears the sticky flags

## Operation
- Field split: guard g = man[16]; sticky s = OR of man[15:0]; lsb = man[17].
- Increment rule inc:
  - RNE: g & (s | lsb)
  - RTZ: 0
  - RDN: sign & (g | s)
  - RUP: ~sign & (g | s)
  - RMM: g
- Normal operand (exp 1..0x7FE):
  - m24 = {1'b0, man[39:17]} + inc.
  - If m24[23] is set (carry out): man becomes 0 and exp becomes exp+1.
  - If exp+1 == 0x7FF: the result is signed infinity (man 0) and o_ov = 1.
  - o_nx = g | s.
- Zero (exp 0, man 0): pass through with sign preserved; o_nx = 0.
- Denormal (exp 0, man ≠ 0): output is signed zero; o_nx = 1. Downstream flushes denormals anyway.
- Infinity (exp 0x7FF, man 0): pass through; no flags.
- NaN (exp 0x7FF, man ≠ 0):
  - Output man = {1'b1, man[38:17], 17'b0}, so the NaN stays a quiet NaN and never collapses to infinity.
  - No flags.
- Sticky flags:
  - fl_nx |= o_nx and fl_ov |= o_ov on each output transfer (o_v & o_rdy).
  - clr_fl clears both flags. If clr_fl coincides with a transfer that would set a flag, the set wins.
- Stage 1 registers: the operand, the decoded class, and the inc/g/s terms. Stage 2 registers the final o_a and the per-result flags.

## Timing
- Latency: 2 cycles from input transfer to o_v, when not stalled.
- Throughput: 1 result per cycle.
- Stage valids: s1_v, s2_v. s2_v drives o_v directly.
- Stall logic:
  - stage 2 advances when ~s2_v | o_rdy;
  - stage 1 advances when ~s1_v | (stage 2 advancing);
  - i_rdy = ~s1_v | (stage 2 advancing).
- Full backpressure:
  - Holding o_rdy low with both stages valid drops i_rdy the same cycle (combinational path).
  - o_a, o_nx and o_ov stay stable while o_v & ~o_rdy.
- Data registers load only on stage advance. Valid bits clear when a stage empties.
- Reset values: s1_v = 0, s2_v = 0, o_v = 0, o_a = 0, o_nx = 0, o_ov = 0, fl_nx = 0, fl_ov = 0.
- i_rdy is 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight results and no flags are set. rst has priority over clr_fl and over transfers.
- i_rm is sampled with i_a at the input transfer; changing it later does not affect in-flight operands.

## Test plan
- 1.0 passthrough: i_a = 52'h3FF_0000000000, RNE, o_rdy = 1.
  - Expect o_v at cycle 2 with o_a = 52'h3FF_0000000000, o_nx = 0, o_ov = 0.
- Tie to even: man = 40'h0000010000, exp 0x3FF, RNE.
  - Expect o_a = 52'h3FF_0000000000, o_nx = 1.
  - Same operand with RUP → o_a = 52'h3FF_0000020000.
  - Same operand with RTZ → 52'h3FF_0000000000.
- Mantissa carry: exp 0x3FF, man 40'hFFFFFF0000, RNE.
  - Expect o_a = 52'h400_0000000000, o_nx = 1.
- Overflow: exp 0x7FE, man 40'hFFFFFF0000, RNE.
  - Expect o_a = 52'h7FF_0000000000, o_ov = 1.
  - fl_ov = 1 after the transfer; pulse clr_fl and expect fl_ov = 0 the next cycle.
- Special classes:
  - denormal 52'h000_0000000001 → o_a = 0, o_nx = 1;
  - −inf 52'hFFF_0000000000 → unchanged;
  - NaN 52'h7FF_0000000001 → 52'h7FF_8000000000, no flags.
- Backpressure and reset:
  - Stream 8 back-to-back operands with o_rdy toggling randomly. Expect all 8 results in order, none dropped or duplicated, and i_rdy = 0 whenever both stages are full and o_rdy = 0.
  - Assert rst with 2 operands in flight. Expect o_v = 0 the next cycle, no flag change, and i_rdy = 1.
